// File: rtl/fir_frame_sequencer.sv
// Frame controller for a transposed FIR: buffers input in a FIFO, clears the filter, then feeds it
// one frame and tags the results valid/last. Define FIR_SEQ_FLUSH_EN to append the TAPS-1 zero tail.
module fir_frame_sequencer #(
  parameter int DIN_W      = 19,
  parameter int DOUT_W     = 20,
  parameter int FRAME_LEN  = 125,
  parameter int TAPS       = 8,
  parameter int LATENCY    = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic [DIN_W-1:0]  in_data_i,
  output logic              in_ready_o,
  output logic              fir_rst_o,
  output logic [DIN_W-1:0]  fir_x_o,
  input  logic [DOUT_W-1:0] fir_y_i,
  output logic              out_valid_o,
  output logic [DOUT_W-1:0] out_data_o,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_underrun_o
);
  localparam int CW = $clog2(FRAME_LEN + TAPS) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef FIR_SEQ_FLUSH_EN
  localparam int N_OUT = FRAME_LEN + TAPS - 1;
`else
  localparam int N_OUT = FRAME_LEN;
`endif
  localparam logic [CW-1:0] LEN_C  = CW'(FRAME_LEN);
  localparam logic [CW-1:0] LAST_C = CW'(N_OUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_FLUSH, S_DRAIN} state_t;
  state_t state_q, state_d;

  logic [DIN_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]      wptr_q, rptr_q, fcnt;
  logic             push, pop, fempty, ffull;

  logic [CW-1:0]      smp_cnt_q, smp_cnt_d, out_cnt_q;
  logic [DIN_W-1:0]   fir_x_q, fir_x_d;
  logic               tag_d, err_q, err_d, fir_rst_q;
  logic [LATENCY:0]   vld_pipe_q;

  // Full/empty come from the registered count, so a push is never poppable in the same cycle.
  assign fcnt       = wptr_q - rptr_q;
  assign fempty     = (fcnt == '0);
  assign ffull      = (fcnt == (AW+1)'(FIFO_DEPTH));
  assign in_ready_o = ~ffull;
  assign push       = in_valid_i & ~ffull;
  assign pop        = (state_q == S_RUN) & ~fempty;

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= in_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    smp_cnt_d = smp_cnt_q;
    fir_x_d   = '0;
    tag_d     = 1'b0;
    err_d     = err_q;
    done_o    = 1'b0;
    case (state_q)
      S_IDLE: if (start_i) begin
        state_d = S_CLR;
        err_d   = 1'b0;
      end
      S_CLR: begin
        smp_cnt_d = '0;
        state_d   = S_RUN;
      end
      S_RUN: begin
        if (!fempty) begin
          fir_x_d   = mem_q[rptr_q[AW-1:0]];
          tag_d     = 1'b1;
          smp_cnt_d = smp_cnt_q + 1'b1;
`ifdef FIR_SEQ_FLUSH_EN
          if (smp_cnt_d == LEN_C) state_d = S_FLUSH;
`else
          if (smp_cnt_d == LEN_C) state_d = S_DRAIN;
`endif
        end else begin
          // Underrun: the zero still reaches the filter, but it is not tagged or counted.
          err_d = 1'b1;
        end
      end
`ifdef FIR_SEQ_FLUSH_EN
      S_FLUSH: begin
        tag_d     = 1'b1;
        smp_cnt_d = smp_cnt_q + 1'b1;
        if (smp_cnt_d == LAST_C + 1'b1) state_d = S_DRAIN;
      end
`endif
      S_DRAIN: if (~|vld_pipe_q) begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      smp_cnt_q  <= '0;
      fir_x_q    <= '0;
      err_q      <= 1'b0;
      fir_rst_q  <= 1'b0;
      vld_pipe_q <= '0;
      out_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      smp_cnt_q  <= smp_cnt_d;
      fir_x_q    <= fir_x_d;
      err_q      <= err_d;
      fir_rst_q  <= (state_d == S_CLR);
      // Stage 0 rides with fir_x; the tail lines up with the matching fir_y.
      vld_pipe_q <= {vld_pipe_q[LATENCY-1:0], tag_d};
      if (state_q == S_CLR)  out_cnt_q <= '0;
      else if (out_valid_o)  out_cnt_q <= out_cnt_q + 1'b1;
    end
  end

  assign fir_rst_o      = fir_rst_q;
  assign fir_x_o        = fir_x_q;
  assign out_valid_o    = vld_pipe_q[LATENCY];
  assign out_data_o     = fir_y_i;
  assign out_last_o     = out_valid_o & (out_cnt_q == LAST_C);
  assign busy_o         = (state_q != S_IDLE);
  assign err_underrun_o = err_q;
endmodule

// File: tb/tb_fir_frame_sequencer.sv
// Scoreboard bench for fir_frame_sequencer: a transposed FIR model closes the loop, and a
// direct convolution of each frame's samples supplies the expected output stream.
module tb_fir_frame_sequencer;
  localparam int DIN_W = 19, DOUT_W = 20, FRAME_LEN = 125, TAPS = 8, FIFO_DEPTH = 16;
`ifdef FIR_SEQ_FLUSH_EN
  localparam int N_OUT = FRAME_LEN + TAPS - 1;
`else
  localparam int N_OUT = FRAME_LEN;
`endif

  logic clk = 1'b0, rst = 1'b0, start_i = 1'b0, in_valid_i = 1'b0;
  logic [DIN_W-1:0]  in_data_i = '0;
  logic              in_ready_o, fir_rst_o, out_valid_o, out_last_o, busy_o, done_o, err_underrun_o;
  logic [DIN_W-1:0]  fir_x_o;
  logic [DOUT_W-1:0] fir_y_i, out_data_o;

  typedef struct {logic [DOUT_W-1:0] d; logic last; bit chk;} exp_t;
  exp_t             exp_q[$];
  logic [DIN_W-1:0] feed_q[$];
  int  H [TAPS] = '{3, -2, 5, 1, -4, 2, 1, -1};
  int  n_vec = 0, n_err = 0, n_acc = 0, nvalid = 0, gaps = 0, last_vcyc = 0, cyc = 0;
  bit  done_seen = 1'b0, prev_last = 1'b0;

  always #5 clk = ~clk;

  fir_frame_sequencer dut (
    .clk(clk), .rst(rst), .start_i(start_i), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
    .in_ready_o(in_ready_o), .fir_rst_o(fir_rst_o), .fir_x_o(fir_x_o), .fir_y_i(fir_y_i),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_last_o(out_last_o),
    .busy_o(busy_o), .done_o(done_o), .err_underrun_o(err_underrun_o)
  );

  // Transposed-form filter with one edge of latency, cleared by fir_rst.
  longint z [1:TAPS-1];
  longint xs;
  assign xs = longint'($signed(fir_x_o));
  always @(posedge clk or posedge rst) begin
    if (rst || fir_rst_o) begin
      fir_y_i <= '0;
      for (int k = 1; k < TAPS; k++) z[k] <= 0;
    end else begin
      fir_y_i <= DOUT_W'(H[0] * xs + z[1]);
      for (int k = 1; k < TAPS - 1; k++) z[k] <= H[k] * xs + z[k+1];
      z[TAPS-1] <= H[TAPS-1] * xs;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Feeder: in_ready seen at one negedge is what the DUT samples at the following posedge.
  initial begin : feeder
    bit rdy;
    rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_valid_i = 1'b0;
        rdy        = 1'b0;
      end else begin
        if (in_valid_i && rdy && feed_q.size() > 0) begin
          void'(feed_q.pop_front());
          n_acc++;
        end
        rdy        = in_ready_o;
        in_valid_i = !rst && feed_q.size() > 0;
        in_data_i  = in_valid_i ? feed_q[0] : '0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) prev_last = 1'b0;
      else begin
        if (prev_last || done_o) chk("done_after_last", done_o, prev_last);
        if (done_o) done_seen = 1'b1;
        if (out_valid_o) begin
          if (nvalid > 0 && cyc - last_vcyc > 1) gaps += cyc - last_vcyc - 1;
          nvalid++;
          last_vcyc = cyc;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_valid: got out_valid=1 expected no output (t=%0t)", $time);
          end else begin
            e = exp_q.pop_front();
            if (e.chk) chk("out_data", out_data_o, e.d);
            chk("out_last", out_last_o, e.last);
          end
        end
        prev_last = out_valid_o && out_last_o;
      end
    end
  end

  // kind: 0 ramp, 1 impulse, 2 random (+ start while busy), 3 underrun, 4 reset mid-RUN
  task automatic run_frame(input int kind);
    int     s [FRAME_LEN];
    longint acc;
    exp_t   e;
    int     ninit;
    for (int i = 0; i < FRAME_LEN; i++)
      s[i] = (kind == 0) ? i + 1 : (kind == 1) ? int'(i == 0)
           : int'($urandom_range(0, (1 << DIN_W) - 1)) - (1 << (DIN_W - 1));
    nvalid = 0; gaps = 0; done_seen = 1'b0; n_acc = 0;
    for (int n = 0; n < N_OUT; n++) begin
      acc = 0;
      for (int k = 0; k < TAPS; k++)
        if (n - k >= 0 && n - k < FRAME_LEN) acc += longint'(H[k]) * s[n-k];
      e.d = DOUT_W'(acc); e.last = (n == N_OUT - 1); e.chk = (kind != 3);
      exp_q.push_back(e);
    end
    ninit = (kind == 3) ? 10 : FRAME_LEN;
    for (int i = 0; i < ninit; i++) feed_q.push_back(DIN_W'(s[i]));
    repeat (25) @(negedge clk);
    if (kind == 0) begin
      chk("preload_accepted", n_acc, FIFO_DEPTH);
      chk("in_ready_when_full", in_ready_o, 0);
    end
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    chk("busy_in_frame", busy_o, 1);
    chk("err_cleared_on_start", err_underrun_o, 0);
    if (kind == 3) begin
      repeat (13) @(negedge clk);
      for (int i = 10; i < FRAME_LEN; i++) feed_q.push_back(DIN_W'(s[i]));
    end
    if (kind == 2) begin
      repeat (40) @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
    end
    if (kind == 4) begin
      repeat (50) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", busy_o, 0);
      chk("abort_in_ready", in_ready_o, 1);
      chk("abort_out_valid", out_valid_o, 0);
      chk("abort_fir_x", fir_x_o, 0);
      exp_q.delete();
      feed_q.delete();
      #14 rst = 1'b0;
      return;
    end
    for (int c = 0; c < 1000 && !done_seen; c++) @(negedge clk);
    chk("done_seen", done_seen, 1);
    @(negedge clk);
    chk("valid_count", nvalid, N_OUT);
    chk("valid_gaps_present", gaps > 0, kind == 3);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("err_underrun", err_underrun_o, kind == 3);
    chk("busy_after_done", busy_o, 0);
    exp_q.delete();
    feed_q.delete();
  endtask

  initial begin : main
    #2 rst = 1'b1;
    #10;
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_fir_rst", fir_rst_o, 0);
    chk("rst_fir_x", fir_x_o, 0);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_out_last", out_last_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err_underrun", err_underrun_o, 0);
    #5 rst = 1'b0;
    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(3);
    run_frame(2);
    run_frame(4);
    run_frame(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fir_frame_sequencer.md
# fir_frame_sequencer

Frame-level controller for the 19-bit-in / 20-bit-out transposed-form FIR datapath. Buffers upstream samples in a small FIFO and clears the filter before each frame. Feeds exactly FRAME_LEN samples plus an optional zero-flush tail into the filter, one per clock. Tags the filter output with a valid/last stream so downstream logic sees only meaningful results.

## Interface
- DIN_W, 19, sample width fed to filter (signed)
- DOUT_W, 20, filter output width (signed)
- FRAME_LEN, 125, samples per frame
- TAPS, 8, filter tap count; flush length = TAPS-1
- LATENCY, 1, clock edges from fir_x change to matching fir_y
- FIFO_DEPTH, 16, input FIFO entries, power of two

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a frame; sampled only in IDLE
- in_valid  in  1  upstream sample valid
- in_data  in  DIN_W  upstream sample
- in_ready  out  1  FIFO not full
- fir_rst  out  1  registered clear pulse to filter rst
- fir_x  out  DIN_W  registered sample to filter input_x
- fir_y  in  DOUT_W  filter output_y
- out_valid  out  1  out_data carries a frame result
- out_data  out  DOUT_W  equals fir_y (pass-through)
- out_last  out  1  with out_valid on final result of frame
- busy  out  1  state not IDLE
- done  out  1  one-cycle pulse, cycle after out_last
- err_underrun  out  1  sticky; cleared on start or rst

## Operation
- FSM states: IDLE, CLR, RUN, FLUSH, DRAIN.
  - IDLE: start=1 -> CLR.
  - CLR: one cycle, fir_rst=1 -> RUN.
  - RUN: sample counter reaches FRAME_LEN -> FLUSH (or DRAIN when flush compiled out).
  - FLUSH: TAPS-1 cycles of fir_x=0 with tag=1 -> DRAIN.
  - DRAIN: wait until the tag pipeline is empty; pulse done -> IDLE.
- FIFO:
  - Push on in_valid && in_ready, in every state.
  - No fall-through; push-while-empty is not poppable the same cycle.
  - Simultaneous push/pop allowed when neither full nor empty.
- RUN, FIFO non-empty: pop; fir_x <= head; tag <= 1; sample count++.
- RUN, FIFO empty (underrun):
  - fir_x <= 0; tag <= 0; count unchanged.
  - err_underrun <= 1.
  - Filter state is corrupted by the inserted zero; only the flag records it.
- Outside RUN/FLUSH: fir_x <= 0, tag <= 0.
- Tag pipeline:
  - Depth LATENCY, shifting the tag.
  - out_valid = pipeline tail; out_data = fir_y.
  - Output counter counts out_valid. out_last is asserted when the count equals FRAME_LEN+TAPS-1 (or FRAME_LEN without flush).
- start while busy: ignored.
- Arithmetic: counters sized clog2(FRAME_LEN+TAPS)+1 bits, unsigned, no wrap within a frame.

## Timing
- Reset values: in_ready=1 (FIFO empty), fir_rst=0, fir_x=0, out_valid=0, out_last=0, busy=0, done=0, err_underrun=0. FIFO is emptied, all counters are 0, state is IDLE.
- rst mid-frame: immediate return to reset values. Buffered samples are discarded, with no partial done.
- Cycle-level frame sequence:
  - Cycle 0: start accepted in IDLE.
  - Cycle 1: CLR, fir_rst=1.
  - Cycle 2 onward: RUN pops.
  - First out_valid appears LATENCY cycles after the first fir_x update.
- No underrun: exactly FRAME_LEN+TAPS-1 contiguous out_valid cycles; done is high the cycle after out_last.
- in_ready is combinational on FIFO count: deasserts in the cycle after the push that fills the FIFO, and reasserts the cycle after a pop.

## Configuration
- FIR_SEQ_FLUSH_EN defined: FLUSH state is present; frame yields FRAME_LEN+TAPS-1 outputs, the last TAPS-1 being the filter tail.
- Undefined: FLUSH logic is absent; RUN goes directly to DRAIN; frame yields FRAME_LEN outputs.

## Test plan
- Reset: assert rst for 15 ns mid-clock -> all outputs at reset values; in_ready=1.
- Ramp frame with flush: preload 16 samples (1..16), start, keep feeding 17..125 without gaps -> 132 out_valid cycles, contiguous; out_data matches reference FIR model; out_last on the 132nd; done one cycle later; err_underrun=0.
- Impulse: frame with x[0]=1 and the rest 0 -> out_data sequence begins with coefficients h0..h7, then zeros.
- Underrun: after 10 samples, drop in_valid for 3 cycles -> three cycles with fir_x=0 and out_valid low; err_underrun=1 until next start; total valid outputs still 132.
- Backpressure: hold in_valid in IDLE -> exactly 16 accepted; in_ready=0 afterward; 17th value accepted only after RUN pops.
- Reset mid-RUN at sample 50 -> busy=0 next edge; FIFO empty; a fresh start produces a full correct frame.
